regfile_wb_arbiter: RTL and testbench

//  Owns the single write port of the 8x16 decode-stage register file.
//  - Arbitrates round-robin between two writeback requesters: A = ALU/execute, B = memory/load.
//  - Sequences clear-one and clear-all requests, either as one pulse or as an 8-cycle sweep.
//  - Flags same-cycle read-after-write hazards for the two decode read addresses.

---
 rtl/regfile_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Owns the single write port of the 8x16 decode-stage register file.
// Arbitrates round-robin between the ALU (A) and load (B) writeback paths.
// Sequences clear-one / clear-all requests, either as a single reset-all
// pulse or as an 8-cycle per-register sweep.
// Flags read-after-write hazards for the two decode read ports.
module regfile_wb_arbiter #(
   parameter int N     = 16,
   parameter bit SWEEP = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         a_valid,
   input  logic [2:0]   a_addr,
   input  logic [N-1:0] a_data,
   output logic         a_ready,
   input  logic         b_valid,
   input  logic [2:0]   b_addr,
   input  logic [N-1:0] b_data,
   output logic         b_ready,
   input  logic         clr_one_req,
   input  logic [2:0]   clr_one_addr,
   input  logic         clr_all_req,
   output logic         busy,
   output logic         rf_we,
   output logic         rf_rst,
   output logic         rf_rst_all,
   output logic [2:0]   rf_waddr,
   output logic [N-1:0] rf_wdata,
   input  logic [2:0]   rd_addr_1,
   input  logic [2:0]   rd_addr_2,
   output logic         haz_1,
   output logic         haz_2
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLR_ALL,
      ST_SWEEP
   } state_t;

   state_t         state;
   state_t         next_state;
   logic           rr_ptr;
   logic           rr_next;
   logic [2:0]     sweep_cnt;
   logic [2:0]     cnt_next;
   logic           grant_a;
   logic           grant_b;
   logic           we_next;
   logic           rst_next;
   logic           rst_all_next;
   logic           busy_next;
   logic [2:0]     waddr_next;
   logic [N-1:0]   wdata_next;

   // Next-state, grant and next-output decode; outputs are registered so the
   // state register and the rf_* outputs always describe the same cycle.
   always_comb begin
      next_state   = state;
      rr_next      = rr_ptr;
      cnt_next     = sweep_cnt;
      grant_a      = 1'b0;
      grant_b      = 1'b0;
      we_next      = 1'b0;
      rst_next     = 1'b0;
      rst_all_next = 1'b0;
      busy_next    = 1'b0;
      waddr_next   = rf_waddr;
      wdata_next   = rf_wdata;
      case (state)
         ST_IDLE: begin
            if (clr_all_req) begin
               busy_next = 1'b1;
               if (SWEEP) begin
                  next_state = ST_SWEEP;
                  cnt_next   = 3'd0;
                  rst_next   = 1'b1;
                  waddr_next = 3'd0;
               end else begin
                  next_state   = ST_CLR_ALL;
                  rst_all_next = 1'b1;
               end
            end else if (clr_one_req) begin
               rst_next   = 1'b1;
               waddr_next = clr_one_addr;
            end else if (rst_n && !rf_rst && !rf_rst_all) begin
               if (a_valid && b_valid) begin
                  grant_a = ~rr_ptr;
                  grant_b = rr_ptr;
                  rr_next = ~rr_ptr;
               end else begin
                  grant_a = a_valid;
                  grant_b = b_valid;
               end
               if (grant_a) begin
                  we_next    = 1'b1;
                  waddr_next = a_addr;
                  wdata_next = a_data;
               end else if (grant_b) begin
                  we_next    = 1'b1;
                  waddr_next = b_addr;
                  wdata_next = b_data;
               end
            end
         end
         ST_CLR_ALL: begin
            next_state = ST_IDLE;
         end
         ST_SWEEP: begin
            if (sweep_cnt == 3'd7) begin
               next_state = ST_IDLE;
               cnt_next   = 3'd0;
            end else begin
               cnt_next   = sweep_cnt + 3'd1;
               rst_next   = 1'b1;
               waddr_next = sweep_cnt + 3'd1;
               busy_next  = 1'b1;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // State, round-robin pointer, sweep counter and registered write-port outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         rr_ptr     <= 1'b0;
         sweep_cnt  <= 3'd0;
         rf_we      <= 1'b0;
         rf_rst     <= 1'b0;
         rf_rst_all <= 1'b0;
         busy       <= 1'b0;
         rf_waddr   <= 3'd0;
         rf_wdata   <= '0;
      end else begin
         state      <= next_state;
         rr_ptr     <= rr_next;
         sweep_cnt  <= cnt_next;
         rf_we      <= we_next;
         rf_rst     <= rst_next;
         rf_rst_all <= rst_all_next;
         busy       <= busy_next;
         rf_waddr   <= waddr_next;
         rf_wdata   <= wdata_next;
      end
   end

   assign a_ready = grant_a & rst_n;
   assign b_ready = grant_b & rst_n;
   assign haz_1   = rf_we & (rf_waddr == rd_addr_1);
   assign haz_2   = rf_we & (rf_waddr == rd_addr_2);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Drives one pulse-mode and one sweep-mode arbiter from shared inputs and
// compares both against a cycle-level reference model of the write port
// plus a modelled register file.
module tb_regfile_wb_arbiter;

   localparam int N = 16;

   logic         clk;
   logic         rst_n;
   logic         a_valid;
   logic [2:0]   a_addr;
   logic [N-1:0] a_data;
   logic         b_valid;
   logic [2:0]   b_addr;
   logic [N-1:0] b_data;
   logic         clr_one_req;
   logic [2:0]   clr_one_addr;
   logic         clr_all_req;
   logic [2:0]   rd_addr_1;
   logic [2:0]   rd_addr_2;

   logic         a_ready    [2];
   logic         b_ready    [2];
   logic         busy       [2];
   logic         rf_we      [2];
   logic         rf_rst     [2];
   logic         rf_rst_all [2];
   logic [2:0]   rf_waddr   [2];
   logic [N-1:0] rf_wdata   [2];
   logic         haz_1      [2];
   logic         haz_2      [2];

   // Reference model: index 0 is pulse mode, index 1 is sweep mode
   bit           m_we    [2];
   bit           m_rst   [2];
   bit           m_all   [2];
   bit           m_busy  [2];
   bit           m_rr    [2];
   logic [2:0]   m_waddr [2];
   logic [N-1:0] m_wdata [2];
   int           m_sweep [2];
   logic [N-1:0] m_rf    [2][8];
   logic [N-1:0] shadow_rf [2][8];
   bit           exp_ga  [2];
   bit           exp_gb  [2];

   int vectors;
   int miscompares;

   regfile_wb_arbiter #(.N(N), .SWEEP(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready[0]),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready[0]),
      .clr_one_req(clr_one_req), .clr_one_addr(clr_one_addr), .clr_all_req(clr_all_req),
      .busy(busy[0]), .rf_we(rf_we[0]), .rf_rst(rf_rst[0]), .rf_rst_all(rf_rst_all[0]),
      .rf_waddr(rf_waddr[0]), .rf_wdata(rf_wdata[0]),
      .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .haz_1(haz_1[0]), .haz_2(haz_2[0])
   );

   regfile_wb_arbiter #(.N(N), .SWEEP(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready[1]),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready[1]),
      .clr_one_req(clr_one_req), .clr_one_addr(clr_one_addr), .clr_all_req(clr_all_req),
      .busy(busy[1]), .rf_we(rf_we[1]), .rf_rst(rf_rst[1]), .rf_rst_all(rf_rst_all[1]),
      .rf_waddr(rf_waddr[1]), .rf_wdata(rf_wdata[1]),
      .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .haz_1(haz_1[1]), .haz_2(haz_2[1])
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Who may write this cycle: no grants in reset, while clearing, while a
   // clear is requested, or while the outputs already carry a clear.
   function automatic void model_grants(input int m);
      exp_ga[m] = 1'b0;
      exp_gb[m] = 1'b0;
      if (rst_n && !m_busy[m] && !m_rst[m] && !m_all[m] && !clr_all_req && !clr_one_req) begin
         if (a_valid && b_valid) begin
            if (m_rr[m]) exp_gb[m] = 1'b1;
            else         exp_ga[m] = 1'b1;
         end else begin
            exp_ga[m] = a_valid;
            exp_gb[m] = b_valid;
         end
      end
   endfunction

   // Commit the current outputs to the modelled regfile, then derive next outputs.
   function automatic void model_edge(input int m);
      if (m_we[m])  m_rf[m][m_waddr[m]] = m_wdata[m];
      if (m_rst[m]) m_rf[m][m_waddr[m]] = '0;
      if (m_all[m]) for (int r = 0; r < 8; r++) m_rf[m][r] = '0;
      if (!rst_n) begin
         m_we[m] = 0; m_rst[m] = 0; m_all[m] = 0; m_busy[m] = 0; m_rr[m] = 0;
         m_sweep[m] = -1; m_waddr[m] = '0; m_wdata[m] = '0;
      end else if (m_sweep[m] >= 0) begin
         if (m_sweep[m] < 7) begin
            m_sweep[m] = m_sweep[m] + 1;
            m_rst[m]   = 1;
            m_waddr[m] = 3'(m_sweep[m]);
            m_busy[m]  = 1;
         end else begin
            m_sweep[m] = -1;
            m_rst[m]   = 0;
            m_busy[m]  = 0;
         end
      end else if (m_all[m]) begin
         m_all[m]  = 0;
         m_busy[m] = 0;
      end else begin
         m_we[m] = 0; m_rst[m] = 0; m_busy[m] = 0;
         if (clr_all_req) begin
            m_busy[m] = 1;
            if (m == 1) begin
               m_sweep[m] = 0;
               m_rst[m]   = 1;
               m_waddr[m] = 3'd0;
            end else begin
               m_all[m] = 1;
            end
         end else if (clr_one_req) begin
            m_rst[m]   = 1;
            m_waddr[m] = clr_one_addr;
         end else if (exp_ga[m]) begin
            m_we[m] = 1; m_waddr[m] = a_addr; m_wdata[m] = a_data;
            if (b_valid) m_rr[m] = !m_rr[m];
         end else if (exp_gb[m]) begin
            m_we[m] = 1; m_waddr[m] = b_addr; m_wdata[m] = b_data;
            if (a_valid) m_rr[m] = !m_rr[m];
         end
      end
   endfunction

   // One clock cycle: combinational checks mid-cycle, registered checks after the edge
   task automatic apply_stimulus();
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         model_grants(m);
         check_output($sformatf("a_ready[%0d]", m), 32'(a_ready[m]), 32'(exp_ga[m]));
         check_output($sformatf("b_ready[%0d]", m), 32'(b_ready[m]), 32'(exp_gb[m]));
         check_output($sformatf("haz_1[%0d]", m), 32'(haz_1[m]),
                      32'(m_we[m] && (m_waddr[m] == rd_addr_1)));
         check_output($sformatf("haz_2[%0d]", m), 32'(haz_2[m]),
                      32'(m_we[m] && (m_waddr[m] == rd_addr_2)));
         if (rf_we[m] === 1'b1)      shadow_rf[m][rf_waddr[m]] = rf_wdata[m];
         if (rf_rst[m] === 1'b1)     shadow_rf[m][rf_waddr[m]] = '0;
         if (rf_rst_all[m] === 1'b1) for (int r = 0; r < 8; r++) shadow_rf[m][r] = '0;
      end
      @(posedge clk);
      for (int m = 0; m < 2; m++) model_edge(m);
      #1;
      for (int m = 0; m < 2; m++) begin
         check_output($sformatf("busy[%0d]", m), 32'(busy[m]), 32'(m_busy[m]));
         check_output($sformatf("rf_we[%0d]", m), 32'(rf_we[m]), 32'(m_we[m]));
         check_output($sformatf("rf_rst[%0d]", m), 32'(rf_rst[m]), 32'(m_rst[m]));
         check_output($sformatf("rf_rst_all[%0d]", m), 32'(rf_rst_all[m]), 32'(m_all[m]));
         if (m_we[m] || m_rst[m])
            check_output($sformatf("rf_waddr[%0d]", m), 32'(rf_waddr[m]), 32'(m_waddr[m]));
         if (m_we[m])
            check_output($sformatf("rf_wdata[%0d]", m), 32'(rf_wdata[m]), 32'(m_wdata[m]));
      end
   endtask

   // Directed scenarios followed by a randomized run
   initial begin
      vectors = 0;
      miscompares = 0;
      for (int m = 0; m < 2; m++) begin
         m_we[m] = 0; m_rst[m] = 0; m_all[m] = 0; m_busy[m] = 0; m_rr[m] = 0;
         m_sweep[m] = -1; m_waddr[m] = '0; m_wdata[m] = '0;
         exp_ga[m] = 0; exp_gb[m] = 0;
         for (int r = 0; r < 8; r++) begin
            m_rf[m][r] = '0;
            shadow_rf[m][r] = '0;
         end
      end
      rst_n = 1'b0; a_valid = 1'b1; a_addr = 3'd3; a_data = 16'h00AA;
      b_valid = 1'b0; b_addr = 3'd0; b_data = '0;
      clr_one_req = 1'b0; clr_one_addr = 3'd0; clr_all_req = 1'b0;
      rd_addr_1 = 3'd0; rd_addr_2 = 3'd0;

      $display("[TB] reset with A pending");
      apply_stimulus();
      apply_stimulus();
      for (int m = 0; m < 2; m++) begin
         check_output("reset_waddr", 32'(rf_waddr[m]), 32'd0);
         check_output("reset_wdata", 32'(rf_wdata[m]), 32'd0);
      end

      $display("[TB] single A write");
      rst_n = 1'b1;
      apply_stimulus();
      check_output("a_only_we", 32'(rf_we[1]), 32'd1);
      check_output("a_only_waddr", 32'(rf_waddr[1]), 32'd3);
      check_output("a_only_wdata", 32'(rf_wdata[1]), 32'h00AA);
      a_valid = 1'b0;
      apply_stimulus();

      $display("[TB] A/B contention on register 5");
      a_valid = 1'b1; a_addr = 3'd5; a_data = 16'h1111;
      b_valid = 1'b1; b_addr = 3'd5; b_data = 16'h2222;
      apply_stimulus();
      check_output("contend_first", 32'(rf_wdata[1]), 32'h1111);
      a_valid = 1'b0;
      apply_stimulus();
      check_output("contend_second", 32'(rf_wdata[1]), 32'h2222);
      b_valid = 1'b0;
      apply_stimulus();
      apply_stimulus();
      for (int m = 0; m < 2; m++)
         check_output("contend_reg5", 32'(shadow_rf[m][5]), 32'h2222);

      $display("[TB] clear-one beats pending A");
      clr_one_req = 1'b1; clr_one_addr = 3'd6;
      a_valid = 1'b1; a_addr = 3'd1; a_data = 16'h1234;
      apply_stimulus();
      check_output("clr_one_rst", 32'(rf_rst[1]), 32'd1);
      check_output("clr_one_waddr", 32'(rf_waddr[1]), 32'd6);
      clr_one_req = 1'b0;
      apply_stimulus();
      apply_stimulus();
      check_output("clr_one_then_a", 32'(rf_we[1]), 32'd1);
      a_valid = 1'b0;
      apply_stimulus();

      $display("[TB] clear-all with requests held during busy");
      clr_all_req = 1'b1;
      apply_stimulus();
      check_output("clr_all_pulse0", 32'(rf_rst_all[0]), 32'd1);
      clr_all_req = 1'b0;
      a_valid = 1'b1; a_addr = 3'd4; a_data = 16'hBEEF;
      clr_one_req = 1'b1; clr_one_addr = 3'd2;
      for (int i = 0; i < 8; i++) begin
         check_output($sformatf("sweep_busy%0d", i), 32'(busy[1]), 32'd1);
         check_output($sformatf("sweep_waddr%0d", i), 32'(rf_waddr[1]), 32'(i));
         if (i == 7) begin
            a_valid = 1'b0;
            clr_one_req = 1'b0;
         end
         apply_stimulus();
      end
      check_output("sweep_done", 32'(busy[1]), 32'd0);
      apply_stimulus();

      $display("[TB] hazard detection");
      a_valid = 1'b1; a_addr = 3'd2; a_data = 16'h5A5A;
      rd_addr_1 = 3'd2; rd_addr_2 = 3'd4;
      apply_stimulus();
      a_valid = 1'b0;
      check_output("haz_1_hit", 32'(haz_1[1]), 32'd1);
      check_output("haz_2_miss", 32'(haz_2[1]), 32'd0);
      apply_stimulus();

      $display("[TB] reset in the middle of a sweep");
      clr_all_req = 1'b1;
      apply_stimulus();
      clr_all_req = 1'b0;
      apply_stimulus();
      apply_stimulus();
      apply_stimulus();
      check_output("abort_at3", 32'(rf_waddr[1]), 32'd3);
      rst_n = 1'b0;
      apply_stimulus();
      rst_n = 1'b1;
      check_output("abort_busy", 32'(busy[1]), 32'd0);
      apply_stimulus();

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         if (!a_valid || exp_ga[1]) begin
            a_valid = 1'($urandom_range(0, 1));
            a_addr  = 3'($urandom_range(0, 7));
            a_data  = 16'($urandom);
         end
         if (!b_valid || exp_gb[1]) begin
            b_valid = 1'($urandom_range(0, 1));
            b_addr  = 3'($urandom_range(0, 7));
            b_data  = 16'($urandom);
         end
         clr_one_req  = ($urandom_range(0, 15) == 0);
         clr_one_addr = 3'($urandom_range(0, 7));
         clr_all_req  = ($urandom_range(0, 47) == 0);
         rst_n        = ($urandom_range(0, 149) != 0);
         rd_addr_1    = 3'($urandom_range(0, 7));
         rd_addr_2    = 3'($urandom_range(0, 7));
         apply_stimulus();
      end

      a_valid = 1'b0; b_valid = 1'b0; clr_one_req = 1'b0; clr_all_req = 1'b0; rst_n = 1'b1;
      apply_stimulus();
      apply_stimulus();
      for (int m = 0; m < 2; m++)
         for (int r = 0; r < 8; r++)
            check_output($sformatf("regfile[%0d][%0d]", m, r),
                         32'(shadow_rf[m][r]), 32'(m_rf[m][r]));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
